// File: rtl/nonce_generator.sv
// nonce_generator
//   Work-unit source for the miner datapath. Holds the 23-word block header,
//   appends the current strided nonce as word 0 of the 24-word SHA message,
//   advances the nonce on request, captures the winning nonce on a comparator
//   hit, counts attempted hashes and flags exhaustion of the nonce range.
//
// Ports
//   clk, n_rst      clock, asynchronous active-low reset
//   load_msg        pulse: latch msg_in as header, restart range, go ACTIVE
//   msg_in          23 header words
//   reset_nonce     pulse: abort job, go IDLE, header kept
//   increment       pulse: advance nonce by STEP
//   result_strobe   pulse: comparator result for current nonce is valid
//   result_valid    comparator hit, qualified by result_strobe
//   msg_out         {header[22:0], nonce}
//   nonce           current nonce
//   active          state == ACTIVE
//   found           sticky winning-nonce flag
//   found_nonce     nonce that produced the hit
//   overflow        sticky range-exhausted flag
//   hash_count      saturating count of result_strobe pulses in this job
module nonce_generator #(
  parameter logic [31:0] NONCE_START = 32'h0000_0000,
  parameter logic [31:0] NONCE_END   = 32'hFFFF_FFFF,
  parameter logic [31:0] STEP        = 32'd1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load_msg,
  input  logic [22:0][31:0] msg_in,
  input  logic              reset_nonce,
  input  logic              increment,
  input  logic              result_strobe,
  input  logic              result_valid,
  output logic [23:0][31:0] msg_out,
  output logic [31:0]       nonce,
  output logic              active,
  output logic              found,
  output logic [31:0]       found_nonce,
  output logic              overflow,
  output logic [31:0]       hash_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    FOUND     = 2'd2,
    EXHAUSTED = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [22:0][31:0] header_q, header_d;
  logic [31:0]       nonce_q, nonce_d;
  logic              found_q, found_d;
  logic [31:0]       found_nonce_q, found_nonce_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       hash_count_q, hash_count_d;
  logic [32:0]       sum;
  logic              hit;

  // 33-bit sum so a step past 32'hFFFF_FFFF is detected instead of wrapping.
  assign sum = {1'b0, nonce_q} + {1'b0, STEP};
  assign hit = result_strobe && result_valid;

  always_comb begin
    state_d       = state_q;
    header_d      = header_q;
    nonce_d       = nonce_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    overflow_d    = overflow_q;
    hash_count_d  = hash_count_q;

    if (load_msg || reset_nonce) begin
      // load_msg wins over reset_nonce; both restart the range.
      nonce_d       = NONCE_START;
      found_d       = 1'b0;
      found_nonce_d = '0;
      overflow_d    = 1'b0;
      hash_count_d  = '0;
      if (load_msg) begin
        header_d = msg_in;
        state_d  = ACTIVE;
      end else begin
        state_d  = IDLE;
      end
    end else if (state_q == ACTIVE) begin
      if (result_strobe && hash_count_q != 32'hFFFF_FFFF)
        hash_count_d = hash_count_q + 32'd1;
      if (hit) begin
        // A hit freezes the nonce at the winning value; a coincident
        // increment is dropped.
        found_nonce_d = nonce_q;
        found_d       = 1'b1;
        state_d       = FOUND;
      end else if (increment) begin
        if (sum > {1'b0, NONCE_END}) begin
          overflow_d = 1'b1;
          state_d    = EXHAUSTED;
        end else begin
          nonce_d = sum[31:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      header_q      <= '0;
      nonce_q       <= NONCE_START;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      overflow_q    <= 1'b0;
      hash_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      header_q      <= header_d;
      nonce_q       <= nonce_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      overflow_q    <= overflow_d;
      hash_count_q  <= hash_count_d;
    end
  end

  assign msg_out     = {header_q, nonce_q};
  assign nonce       = nonce_q;
  assign active      = (state_q == ACTIVE);
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign overflow    = overflow_q;
  assign hash_count  = hash_count_q;

endmodule

// File: tb/tb_nonce_generator.sv
module tb_nonce_generator;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              load_msg, reset_nonce, increment, result_strobe, result_valid;
  logic [22:0][31:0] msg_in;

  // a: default parameters; s: START=0 END=3 STEP=2; m: START=FFFF_FFFF
  logic [23:0][31:0] msg_out_a, msg_out_s, msg_out_m;
  logic [31:0]       nonce_a, nonce_s, nonce_m;
  logic              active_a, active_s, active_m;
  logic              found_a, found_s, found_m;
  logic [31:0]       found_nonce_a, found_nonce_s, found_nonce_m;
  logic              overflow_a, overflow_s, overflow_m;
  logic [31:0]       hash_count_a, hash_count_s, hash_count_m;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nonce_generator dut_a (
    .clk(clk), .n_rst(n_rst), .load_msg(load_msg), .msg_in(msg_in),
    .reset_nonce(reset_nonce), .increment(increment),
    .result_strobe(result_strobe), .result_valid(result_valid),
    .msg_out(msg_out_a), .nonce(nonce_a), .active(active_a), .found(found_a),
    .found_nonce(found_nonce_a), .overflow(overflow_a), .hash_count(hash_count_a)
  );

  nonce_generator #(.NONCE_START(32'h0), .NONCE_END(32'h3), .STEP(32'd2)) dut_s (
    .clk(clk), .n_rst(n_rst), .load_msg(load_msg), .msg_in(msg_in),
    .reset_nonce(reset_nonce), .increment(increment),
    .result_strobe(result_strobe), .result_valid(result_valid),
    .msg_out(msg_out_s), .nonce(nonce_s), .active(active_s), .found(found_s),
    .found_nonce(found_nonce_s), .overflow(overflow_s), .hash_count(hash_count_s)
  );

  nonce_generator #(.NONCE_START(32'hFFFF_FFFF)) dut_m (
    .clk(clk), .n_rst(n_rst), .load_msg(load_msg), .msg_in(msg_in),
    .reset_nonce(reset_nonce), .increment(increment),
    .result_strobe(result_strobe), .result_valid(result_valid),
    .msg_out(msg_out_m), .nonce(nonce_m), .active(active_m), .found(found_m),
    .found_nonce(found_nonce_m), .overflow(overflow_m), .hash_count(hash_count_m)
  );

  // One-cycle pulse; outputs are sampled 1 time unit after the capturing edge.
  task automatic pulse(input logic ld, input logic rn, input logic inc,
                       input logic rs, input logic rv);
    load_msg = ld; reset_nonce = rn; increment = inc;
    result_strobe = rs; result_valid = rv;
    @(posedge clk); #1;
    load_msg = 0; reset_nonce = 0; increment = 0;
    result_strobe = 0; result_valid = 0;
  endtask

  task automatic set_header(input logic [31:0] base);
    for (int i = 0; i < 23; i++) msg_in[i] = base + i;
  endtask

  task automatic test_reset;
    n_rst = 0; #12;
    tests++; if (active_a !== 1'b0 || found_a !== 1'b0 || overflow_a !== 1'b0) begin
      fails++; $display("FAIL reset_flags got act=%b fnd=%b ovf=%b exp 0 0 0", active_a, found_a, overflow_a); end
    tests++; if (msg_out_a !== '0 || nonce_a !== 32'h0) begin
      fails++; $display("FAIL reset_msg got nonce=%h exp 0 msg_out nonzero=%b", nonce_a, |msg_out_a); end
    tests++; if (hash_count_a !== 32'h0 || found_nonce_a !== 32'h0) begin
      fails++; $display("FAIL reset_cnt got hc=%h fn=%h exp 0 0", hash_count_a, found_nonce_a); end
    tests++; if (msg_out_m[0] !== 32'hFFFF_FFFF || nonce_m !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL reset_start got %h exp ffffffff", msg_out_m[0]); end
    @(negedge clk); n_rst = 1; @(posedge clk); #1;
  endtask

  task automatic test_load;
    set_header(32'h1000_0000);
    pulse(1, 0, 0, 0, 0);
    tests++; if (active_a !== 1'b1) begin
      fails++; $display("FAIL load_active got %b exp 1", active_a); end
    tests++; if (nonce_a !== 32'h0 || msg_out_a[0] !== 32'h0) begin
      fails++; $display("FAIL load_nonce got %h/%h exp 0", nonce_a, msg_out_a[0]); end
    tests++; if (msg_out_a[23] !== 32'h1000_0016 || msg_out_a[1] !== 32'h1000_0000) begin
      fails++; $display("FAIL load_header got w23=%h w1=%h exp 10000016 10000000", msg_out_a[23], msg_out_a[1]); end
  endtask

  task automatic test_count;
    pulse(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      pulse(0, 0, 1, 0, 0);
      pulse(0, 0, 0, 1, 0);
    end
    // comparator hit without strobe must be ignored
    pulse(0, 0, 0, 0, 1);
    tests++; if (nonce_a !== 32'd5) begin
      fails++; $display("FAIL count_nonce got %h exp 5", nonce_a); end
    tests++; if (hash_count_a !== 32'd5) begin
      fails++; $display("FAIL count_hash got %0d exp 5", hash_count_a); end
    tests++; if (found_a !== 1'b0 || active_a !== 1'b1) begin
      fails++; $display("FAIL count_state got fnd=%b act=%b exp 0 1", found_a, active_a); end
  endtask

  task automatic test_stride;
    pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    tests++; if (nonce_s !== 32'd2 || overflow_s !== 1'b0) begin
      fails++; $display("FAIL stride_first got n=%h ovf=%b exp 2 0", nonce_s, overflow_s); end
    pulse(0, 0, 1, 0, 0);
    tests++; if (nonce_s !== 32'd2 || overflow_s !== 1'b1 || active_s !== 1'b0) begin
      fails++; $display("FAIL stride_ovf got n=%h ovf=%b act=%b exp 2 1 0", nonce_s, overflow_s, active_s); end
    pulse(0, 0, 1, 1, 0);
    tests++; if (nonce_s !== 32'd2 || overflow_s !== 1'b1 || hash_count_s !== 32'd0) begin
      fails++; $display("FAIL stride_hold got n=%h ovf=%b hc=%0d exp 2 1 0", nonce_s, overflow_s, hash_count_s); end
  endtask

  task automatic test_hit;
    pulse(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) pulse(0, 0, 1, 0, 0);
    pulse(0, 0, 1, 1, 1);
    tests++; if (found_a !== 1'b1 || found_nonce_a !== 32'd7) begin
      fails++; $display("FAIL hit_capture got fnd=%b fn=%h exp 1 7", found_a, found_nonce_a); end
    tests++; if (nonce_a !== 32'd7 || hash_count_a !== 32'd1 || active_a !== 1'b0) begin
      fails++; $display("FAIL hit_state got n=%h hc=%0d act=%b exp 7 1 0", nonce_a, hash_count_a, active_a); end
    pulse(0, 0, 1, 1, 0);
    tests++; if (nonce_a !== 32'd7 || hash_count_a !== 32'd1 || found_a !== 1'b1) begin
      fails++; $display("FAIL hit_hold got n=%h hc=%0d fnd=%b exp 7 1 1", nonce_a, hash_count_a, found_a); end
  endtask

  task automatic test_reset_nonce;
    pulse(0, 1, 0, 0, 0);
    tests++; if (active_a !== 1'b0 || found_a !== 1'b0 || found_nonce_a !== 32'h0 ||
                 nonce_a !== 32'h0 || hash_count_a !== 32'h0) begin
      fails++; $display("FAIL rn_clear got act=%b fnd=%b fn=%h n=%h hc=%0d exp 0 0 0 0 0",
                        active_a, found_a, found_nonce_a, nonce_a, hash_count_a); end
    tests++; if (msg_out_a[23] !== 32'h1000_0016) begin
      fails++; $display("FAIL rn_header got %h exp 10000016", msg_out_a[23]); end
    pulse(0, 0, 1, 0, 0);
    tests++; if (nonce_a !== 32'h0) begin
      fails++; $display("FAIL idle_ignore got %h exp 0", nonce_a); end
    set_header(32'h2000_0000);
    pulse(1, 1, 0, 0, 0);
    tests++; if (active_a !== 1'b1 || msg_out_a[23] !== 32'h2000_0016) begin
      fails++; $display("FAIL ld_rn_prio got act=%b w23=%h exp 1 20000016", active_a, msg_out_a[23]); end
  endtask

  task automatic test_back_to_back;
    pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 1, 1, 0);
    tests++; if (nonce_a !== 32'd1 || hash_count_a !== 32'd1) begin
      fails++; $display("FAIL b2b_both got n=%h hc=%0d exp 1 1", nonce_a, hash_count_a); end
    increment = 1;
    repeat (3) @(posedge clk);
    #1 increment = 0;
    tests++; if (nonce_a !== 32'd4 || msg_out_a[0] !== 32'd4) begin
      fails++; $display("FAIL b2b_inc got %h exp 4", nonce_a); end
  endtask

  task automatic test_wrap;
    pulse(1, 0, 0, 0, 0);
    tests++; if (nonce_m !== 32'hFFFF_FFFF || active_m !== 1'b1) begin
      fails++; $display("FAIL wrap_start got n=%h act=%b exp ffffffff 1", nonce_m, active_m); end
    pulse(0, 0, 1, 0, 0);
    tests++; if (overflow_m !== 1'b1 || nonce_m !== 32'hFFFF_FFFF || active_m !== 1'b0) begin
      fails++; $display("FAIL wrap_ovf got ovf=%b n=%h act=%b exp 1 ffffffff 0", overflow_m, nonce_m, active_m); end
  endtask

  task automatic test_async_reset;
    pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    @(negedge clk); #2 n_rst = 0; #1;
    tests++; if (active_a !== 1'b0 || nonce_a !== 32'h0 || msg_out_a[23] !== 32'h0) begin
      fails++; $display("FAIL async_rst got act=%b n=%h w23=%h exp 0 0 0", active_a, nonce_a, msg_out_a[23]); end
    #3 n_rst = 1;
  endtask

  initial begin
    load_msg = 0; reset_nonce = 0; increment = 0;
    result_strobe = 0; result_valid = 0;
    msg_in = '0;
    test_reset;
    test_load;
    test_count;
    test_stride;
    test_hit;
    test_reset_nonce;
    test_back_to_back;
    test_wrap;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
